// File: rtl/pong_timer.sv
// Ball-step and end-of-game timer for the pong light-pattern FSM.
// Define PONG_TIMER_LEVEL_SPEEDUP_EN to shorten the step period with level.
module pong_timer #(
    parameter int unsigned STEP_CYCLES = 5000000,
    parameter int unsigned END_CYCLES  = 500000000,
    parameter int unsigned LEVEL_DEC   = 250000,
    parameter int unsigned MIN_STEP    = 1000000
) (
    input  logic       Clk,
    input  logic       r,
    input  logic       EnTimer20,
    input  logic       EnTimer5,
    input  logic [3:0] level,
    output logic       Time20,
    output logic       Time5,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        END_RUN,
        END_DONE
    } state_t;

    localparam logic [31:0] STEP_W = 32'(STEP_CYCLES);
    localparam logic [31:0] END_W  = 32'(END_CYCLES);
    localparam logic [31:0] DEC_W  = 32'(LEVEL_DEC);
    localparam logic [31:0] MIN_W  = 32'(MIN_STEP);

    state_t      state, state_d;
    logic [31:0] scnt, scnt_d;
    logic [31:0] ecnt, ecnt_d;
    logic [31:0] period, period_d;
    logic [31:0] period_calc;
    logic        s_last;
    logic        e_last;

`ifdef PONG_TIMER_LEVEL_SPEEDUP_EN
    logic [31:0] dec;

    // Clamp before subtracting so a large level never underflows.
    always_comb begin
        dec = {28'd0, level} * DEC_W;
        if (dec >= STEP_W) begin
            period_calc = MIN_W;
        end else if ((STEP_W - dec) < MIN_W) begin
            period_calc = MIN_W;
        end else begin
            period_calc = STEP_W - dec;
        end
    end
`else
    logic unused_level;

    assign unused_level = ^level;
    assign period_calc  = STEP_W;
`endif

    assign s_last = (scnt == period - 32'd1);
    assign e_last = (ecnt == END_W - 32'd1);

    always_comb begin
        state_d = state;
        scnt_d  = scnt;
        ecnt_d  = ecnt;
        if (EnTimer5) begin
            scnt_d = 32'd0;
            unique case (state)
                IDLE, STEP: begin
                    state_d = END_RUN;
                    ecnt_d  = 32'd0;
                end
                END_RUN: begin
                    if (e_last) begin
                        state_d = END_DONE;
                    end else begin
                        ecnt_d = ecnt + 32'd1;
                    end
                end
                END_DONE: begin
                    state_d = END_DONE;
                end
                default: state_d = IDLE;
            endcase
        end else begin
            ecnt_d = 32'd0;
            unique case (state)
                IDLE: begin
                    scnt_d  = 32'd0;
                    state_d = EnTimer20 ? STEP : IDLE;
                end
                STEP: begin
                    if (!EnTimer20) begin
                        state_d = IDLE;
                        scnt_d  = 32'd0;
                    end else if (s_last) begin
                        scnt_d = 32'd0;
                    end else begin
                        scnt_d = scnt + 32'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    scnt_d  = 32'd0;
                end
            endcase
        end
    end

    // The period is only sampled when a new step period begins.
    assign period_d = (scnt_d == 32'd0) ? period_calc : period;

    always_ff @(posedge Clk) begin
        if (r) begin
            state  <= IDLE;
            scnt   <= 32'd0;
            ecnt   <= 32'd0;
            period <= STEP_W;
        end else begin
            state  <= state_d;
            scnt   <= scnt_d;
            ecnt   <= ecnt_d;
            period <= period_d;
        end
    end

    assign Time20 = (state == STEP) && EnTimer20 && !EnTimer5 && s_last;
    assign Time5  = (state == END_DONE);
    assign busy   = (state != IDLE);

endmodule
